// File: rtl/memory_access_sequencer.sv
// ---------------------------------------------------------------------------
// memory_access_sequencer
//
// Breaks one 8/16/32-bit load or store into byte accesses on a byte-wide
// synchronous RAM. Each lane has its own address, so the bytes of one access
// can land anywhere in RAM. For example, the address handler can supply a
// descending address sequence for a downward-growing stack. Lanes go out one
// per cycle in the order Byte0, Byte1, Byte2, Byte3. Load bytes are put back
// together into rdata.
//
// Optional build macro: MAS_SENTINEL_CHECK_EN
//   When defined, a request is rejected if any used lane address equals
//   32'hFFFFFFFF (empty-stack pop). A rejected request skips RAM access,
//   finishes in DONE with error=1, and returns rdata=32'hFFFFFFFF.
//   When undefined, error is tied to 0 and no address is checked.
//
// Parameters
//   ADDR_W     RAM address width (low bits of each lane address)
//
// Ports
//   clock      sole clock, rising edge
//   reset      asynchronous active-low reset
//   start      request strobe, only looked at in IDLE
//   write      1 = store, 0 = load (latched at accept)
//   size       0 = byte, 1 = half, 2/3 = word (latched at accept)
//   Byte3..0   per-lane byte addresses (latched at accept)
//   wdata      store data, lane k = wdata[8k+7:8k] (latched at accept)
//   mem_rdata  RAM read byte, valid one cycle after its address
//   mem_addr   RAM address, zero outside ACCESS
//   mem_wdata  RAM write byte, zero outside ACCESS
//   mem_we     RAM write enable
//   rdata      assembled load word, unused lanes zero
//   busy       high in ACCESS, DRAIN, DONE
//   done       one-cycle pulse in DONE
//   error      sentinel address seen (only with MAS_SENTINEL_CHECK_EN)
// ---------------------------------------------------------------------------
module memory_access_sequencer #(
   parameter int ADDR_W = 14
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   input  logic              write,
   input  logic [1:0]        size,
   input  logic [31:0]       Byte3,
   input  logic [31:0]       Byte2,
   input  logic [31:0]       Byte1,
   input  logic [31:0]       Byte0,
   input  logic [31:0]       wdata,
   input  logic [7:0]        mem_rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_wdata,
   output logic              mem_we,
   output logic [31:0]       rdata,
   output logic              busy,
   output logic              done,
   output logic              error
);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_ACCESS = 2'd1;
   localparam logic [1:0] ST_DRAIN  = 2'd2;
   localparam logic [1:0] ST_DONE   = 2'd3;

   localparam logic [31:0] SENTINEL = 32'hFFFF_FFFF;

   logic [1:0]        state_q;
   logic [1:0]        lane_q;
   logic [1:0]        last_q;
   logic              wr_q;
   logic [ADDR_W-1:0] addr_q [4];
   logic [31:0]       wdata_q;
   logic [31:0]       rdata_q;
   logic              accept;
   logic              sentinel;

   // Load capture pipeline: lane number of the address presented last cycle
   logic              vld_p1;
   logic [1:0]        cap_lane_p1;

   // Address bits above ADDR_W are deliberately dropped (no wrap detection)
   logic              unused_addr_bits;
   assign unused_addr_bits = ^{Byte3[31:ADDR_W], Byte2[31:ADDR_W],
                               Byte1[31:ADDR_W], Byte0[31:ADDR_W]};

   // Index of the final lane: 0 for byte, 1 for half, 3 for word
   function automatic logic [1:0] last_lane_of(input logic [1:0] sz);
      case (sz)
         2'd0:    return 2'd0;
         2'd1:    return 2'd1;
         default: return 2'd3;
      endcase
   endfunction

   function automatic logic [7:0] lane_byte(input logic [31:0] w, input logic [1:0] k);
      return w[{k, 3'b000} +: 8];
   endfunction

   assign accept = (state_q == ST_IDLE) && start;

`ifdef MAS_SENTINEL_CHECK_EN
   logic error_q;

   // Only lanes that the request size actually uses are checked
   always_comb begin
      sentinel = (Byte0 == SENTINEL);
      if (size != 2'd0)
         sentinel = sentinel || (Byte1 == SENTINEL);
      if (size[1])
         sentinel = sentinel || (Byte2 == SENTINEL) || (Byte3 == SENTINEL);
   end

   assign error = error_q;
`else
   assign sentinel = 1'b0;
   assign error    = 1'b0;
`endif

   // Request latch (data only, loaded at accept)
   always_ff @(posedge clock) begin
      if (accept) begin
         addr_q[0] <= Byte0[ADDR_W-1:0];
         addr_q[1] <= Byte1[ADDR_W-1:0];
         addr_q[2] <= Byte2[ADDR_W-1:0];
         addr_q[3] <= Byte3[ADDR_W-1:0];
         wdata_q   <= wdata;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         lane_q      <= 2'd0;
         last_q      <= 2'd0;
         wr_q        <= 1'b0;
         rdata_q     <= 32'd0;
         vld_p1      <= 1'b0;
         cap_lane_p1 <= 2'd0;
`ifdef MAS_SENTINEL_CHECK_EN
         error_q     <= 1'b0;
`endif
      end else begin
         // Stage p0 -> p1: remember which load lane was addressed this cycle
         vld_p1      <= (state_q == ST_ACCESS) && !wr_q;
         cap_lane_p1 <= lane_q;

         // Stage p1: RAM byte for that lane is now on mem_rdata
         if (vld_p1)
            rdata_q[{cap_lane_p1, 3'b000} +: 8] <= mem_rdata;

         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  wr_q    <= write;
                  last_q  <= last_lane_of(size);
                  lane_q  <= 2'd0;
                  rdata_q <= sentinel ? SENTINEL : 32'd0;
`ifdef MAS_SENTINEL_CHECK_EN
                  error_q <= sentinel;
`endif
                  state_q <= sentinel ? ST_DONE : ST_ACCESS;
               end
            end
            ST_ACCESS: begin
               if (lane_q == last_q)
                  // Loads need one more cycle to capture the final RAM byte
                  state_q <= wr_q ? ST_DONE : ST_DRAIN;
               else
                  lane_q <= lane_q + 2'd1;
            end
            ST_DRAIN: begin
               state_q <= ST_DONE;
            end
            default: begin
               lane_q  <= 2'd0;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   // RAM interface is only active in ACCESS
   always_comb begin
      mem_addr  = '0;
      mem_wdata = 8'd0;
      mem_we    = 1'b0;
      if (state_q == ST_ACCESS) begin
         mem_addr = addr_q[lane_q];
         mem_we   = wr_q;
         if (wr_q)
            mem_wdata = lane_byte(wdata_q, lane_q);
      end
   end

   assign rdata = rdata_q;
   assign busy  = (state_q != ST_IDLE);
   assign done  = (state_q == ST_DONE);

endmodule

// File: tb/tb_memory_access_sequencer.sv
// ---------------------------------------------------------------------------
// Bench for memory_access_sequencer. A byte-wide synchronous RAM is modelled
// behind the DUT. A shadow copy of RAM contents gives the expected load data.
// Directed vectors come from a table. Hand-written sequences cover held
// start, reset in the middle of a transfer, and sentinel addresses. Random
// transactions are compared against the shadow model.
// ---------------------------------------------------------------------------
module tb_memory_access_sequencer;
   localparam int ADDR_W = 14;
   localparam int DEPTH  = 1 << ADDR_W;

   logic              clock = 1'b0;
   logic              reset = 1'b1;
   logic              start = 1'b0;
   logic              write = 1'b0;
   logic [1:0]        size  = 2'd0;
   logic [31:0]       Byte3 = 32'd0;
   logic [31:0]       Byte2 = 32'd0;
   logic [31:0]       Byte1 = 32'd0;
   logic [31:0]       Byte0 = 32'd0;
   logic [31:0]       wdata = 32'd0;
   logic [7:0]        mem_rdata;
   logic [ADDR_W-1:0] mem_addr;
   logic [7:0]        mem_wdata;
   logic              mem_we;
   logic [31:0]       rdata;
   logic              busy;
   logic              done;
   logic              error;

   always #5 clock = ~clock;

   memory_access_sequencer #(.ADDR_W(ADDR_W)) dut (
      .clock(clock), .reset(reset), .start(start), .write(write), .size(size),
      .Byte3(Byte3), .Byte2(Byte2), .Byte1(Byte1), .Byte0(Byte0), .wdata(wdata),
      .mem_rdata(mem_rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_we(mem_we), .rdata(rdata), .busy(busy), .done(done), .error(error)
   );

   // Byte-wide synchronous RAM
   logic [7:0] ram [DEPTH];
   always @(posedge clock) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      mem_rdata <= ram[mem_addr];
   end

   logic [7:0] shadow [DEPTH];
   int total = 0;
   int bad   = 0;

   typedef struct {
      logic        wr;
      logic [1:0]  sz;
      logic [31:0] b3, b2, b1, b0;
      logic [31:0] wd;
      logic [31:0] exp_rd;
      int          exp_done;
   } vec_t;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
      end
   endtask

   function automatic int lanes_of(input logic [1:0] sz);
      return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
   endfunction

   // Expected load word: lane k takes the shadow byte at Byte k's low bits
   function automatic logic [31:0] model_load(input logic [1:0] sz,
         input logic [31:0] b3, input logic [31:0] b2, input logic [31:0] b1, input logic [31:0] b0);
      logic [31:0] ba [4];
      logic [31:0] r;
      ba[0] = b0; ba[1] = b1; ba[2] = b2; ba[3] = b3;
      r = 32'd0;
      for (int k = 0; k < lanes_of(sz); k++)
         r[8*k +: 8] = shadow[ba[k][ADDR_W-1:0]];
      return r;
   endfunction

   task automatic run_txn(input string nm, input logic wr, input logic [1:0] sz,
         input logic [31:0] b3, input logic [31:0] b2, input logic [31:0] b1, input logic [31:0] b0,
         input logic [31:0] wd, input logic [31:0] exp_rd, input int exp_done);
      logic [31:0]       ba [4];
      logic [ADDR_W-1:0] wa [$];
      logic [7:0]        wb [$];
      logic [31:0]       rd_d, rd_h;
      logic              er_d;
      logic [31:0]       io_d;
      int                n, dc, busy_low;
      ba[0] = b0; ba[1] = b1; ba[2] = b2; ba[3] = b3;
      n = lanes_of(sz);
      dc = 0; busy_low = 0; rd_d = 'x; er_d = 1'bx; io_d = 'x;
      @(negedge clock);
      write = wr; size = sz; Byte3 = b3; Byte2 = b2; Byte1 = b1; Byte0 = b0; wdata = wd;
      start = 1'b1;
      @(posedge clock);
      #1 start = 1'b0;
      for (int c = 1; c <= 12 && dc == 0; c++) begin
         @(negedge clock);
         if (!busy) busy_low++;
         if (mem_we) begin
            wa.push_back(mem_addr);
            wb.push_back(mem_wdata);
         end
         if (done) begin
            dc = c; rd_d = rdata; er_d = error;
            io_d = {10'd0, mem_addr, mem_wdata};
         end
      end
      chk($sformatf("%s done_cycle", nm), 32'(dc), 32'(exp_done));
      chk($sformatf("%s busy_low", nm), 32'(busy_low), 32'd0);
      chk($sformatf("%s write_count", nm), 32'(wa.size()), wr ? 32'(n) : 32'd0);
      if (wr) begin
         for (int k = 0; k < n; k++) begin
            if (k < wa.size()) begin
               chk($sformatf("%s lane%0d addr", nm, k), 32'(wa[k]), 32'(ba[k][ADDR_W-1:0]));
               chk($sformatf("%s lane%0d data", nm, k), 32'(wb[k]), 32'(wd[8*k +: 8]));
            end
            shadow[ba[k][ADDR_W-1:0]] = wd[8*k +: 8];
         end
      end
      chk($sformatf("%s rdata", nm), rd_d, exp_rd);
      chk($sformatf("%s error", nm), 32'(er_d), 32'd0);
      chk($sformatf("%s idle_bus_in_done", nm), io_d, 32'd0);
      @(negedge clock);
      chk($sformatf("%s after_done busy/done", nm), {30'd0, busy, done}, 32'd0);
      rd_h = rdata;
      chk($sformatf("%s rdata_hold", nm), rd_h, rd_d);
   endtask

   initial begin
      vec_t        tbl [10];
      logic [31:0] ra [4];
      logic [31:0] r, wd, exp;
      logic        wr;
      logic [1:0]  sz;
      int          dc, nwe;

      //            wr    sz    b3            b2            b1            b0            wd            exp_rd        done
      tbl[0] = '{1'b1, 2'd2, 32'h0000_17FC, 32'h0000_17FD, 32'h0000_17FE, 32'h0000_17FF, 32'hA1B2_C3D4, 32'h0,         5};
      tbl[1] = '{1'b0, 2'd2, 32'h0000_17FC, 32'h0000_17FD, 32'h0000_17FE, 32'h0000_17FF, 32'h0,         32'hA1B2_C3D4, 6};
      tbl[2] = '{1'b1, 2'd1, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0000_1001, 32'h0000_1002, 32'h0000_5A3C, 32'h0,         3};
      tbl[3] = '{1'b0, 2'd1, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0000_1001, 32'h0000_1002, 32'h0,         32'h0000_5A3C, 4};
      tbl[4] = '{1'b1, 2'd0, 32'h0,         32'h0,         32'h0,         32'h0000_0200, 32'hCAFE_EE77, 32'h0,         2};
      tbl[5] = '{1'b0, 2'd0, 32'h0,         32'h0,         32'h0,         32'h0000_0200, 32'h0,         32'h0000_0077, 3};
      tbl[6] = '{1'b1, 2'd3, 32'h7FFF_3F63, 32'h8000_3F62, 32'h0001_3F61, 32'hABCD_3F60, 32'h0BAD_F00D, 32'h0,         5};
      tbl[7] = '{1'b0, 2'd3, 32'h0000_3F63, 32'h0000_3F62, 32'h0000_3F61, 32'h0000_3F60, 32'h0,         32'h0BAD_F00D, 6};
      tbl[8] = '{1'b1, 2'd2, 32'h0000_3F53, 32'h0000_3F52, 32'h0000_3F51, 32'h0000_3F50, 32'h0,         32'h0,         5};
      tbl[9] = '{1'b0, 2'd0, 32'h0,         32'h0,         32'h0,         32'h0000_3F50, 32'h0,         32'h0,         3};

      // Reset asserted with start high: nothing may be accepted
      #2 reset = 1'b0;
      write = 1'b1; start = 1'b1; Byte0 = 32'h0000_0123;
      repeat (3) @(negedge clock);
      chk("reset status", {28'd0, busy, done, mem_we, error}, 32'd0);
      chk("reset mem_addr", 32'(mem_addr), 32'd0);
      chk("reset mem_wdata", 32'(mem_wdata), 32'd0);
      chk("reset rdata", rdata, 32'd0);
      start = 1'b0; reset = 1'b1;
      @(negedge clock);
      chk("post-reset busy", 32'(busy), 32'd0);

      for (int i = 0; i < 10; i++)
         run_txn($sformatf("vec%0d", i), tbl[i].wr, tbl[i].sz, tbl[i].b3, tbl[i].b2,
                 tbl[i].b1, tbl[i].b0, tbl[i].wd, tbl[i].exp_rd, tbl[i].exp_done);

      // Reset in the middle of a word store: lanes 0,1 written, 2,3 not
      @(negedge clock);
      write = 1'b1; size = 2'd2; wdata = 32'hDEAD_BEEF;
      Byte0 = 32'h3F50; Byte1 = 32'h3F51; Byte2 = 32'h3F52; Byte3 = 32'h3F53;
      start = 1'b1;
      @(posedge clock);
      #1 start = 1'b0;
      @(negedge clock);
      chk("midrst lane0 addr", 32'(mem_addr), 32'h3F50);
      @(negedge clock);
      @(negedge clock);
      chk("midrst lane2 presented", {31'd0, mem_we}, 32'd1);
      reset = 1'b0; start = 1'b1;
      #1;
      chk("midrst status", {28'd0, busy, done, mem_we, error}, 32'd0);
      chk("midrst bus", {10'd0, mem_addr, mem_wdata}, 32'd0);
      chk("midrst rdata", rdata, 32'd0);
      nwe = 0;
      repeat (2) begin
         @(negedge clock);
         if (mem_we || busy) nwe++;
      end
      chk("midrst quiet in reset", 32'(nwe), 32'd0);
      start = 1'b0; reset = 1'b1;
      shadow[14'h3F50] = 8'hEF;
      shadow[14'h3F51] = 8'hBE;
      run_txn("midrst readback", 1'b0, 2'd2, 32'h3F53, 32'h3F52, 32'h3F51, 32'h3F50,
              32'd0, 32'h0000_BEEF, 6);

      // start held high while busy: second request waits until after done
      @(negedge clock);
      write = 1'b1; size = 2'd2; wdata = 32'h1122_3344;
      Byte0 = 32'h3F40; Byte1 = 32'h3F41; Byte2 = 32'h3F42; Byte3 = 32'h3F43;
      start = 1'b1;
      @(posedge clock);
      #1;
      size = 2'd0; wdata = 32'h0000_0055; Byte0 = 32'h3F44;
      dc = 0; nwe = 0;
      for (int c = 1; c <= 6; c++) begin
         @(negedge clock);
         if (mem_we) nwe++;
         if (done && dc == 0) dc = c;
         if (c == 6) chk("held idle busy", 32'(busy), 32'd0);
      end
      chk("held first done", 32'(dc), 32'd5);
      chk("held first writes", 32'(nwe), 32'd4);
      @(negedge clock);
      chk("held second accepted", {30'd0, busy, mem_we}, 32'd3);
      chk("held second bus", {10'd0, mem_addr, mem_wdata}, {10'd0, 14'h3F44, 8'h55});
      start = 1'b0;
      @(negedge clock);
      chk("held second done", 32'(done), 32'd1);
      shadow[14'h3F40] = 8'h44; shadow[14'h3F41] = 8'h33;
      shadow[14'h3F42] = 8'h22; shadow[14'h3F43] = 8'h11;
      shadow[14'h3F44] = 8'h55;
      run_txn("held readback", 1'b0, 2'd3, 32'h3F44, 32'h3F42, 32'h3F41, 32'h3F40,
              32'd0, 32'h5522_3344, 6);

`ifdef MAS_SENTINEL_CHECK_EN
      // Empty-stack pop: no RAM access, done next cycle with error
      @(negedge clock);
      write = 1'b0; size = 2'd2;
      Byte0 = 32'hFFFF_FFFF; Byte1 = 32'hFFFF_FFFF; Byte2 = 32'hFFFF_FFFF; Byte3 = 32'hFFFF_FFFF;
      start = 1'b1;
      @(posedge clock);
      #1 start = 1'b0;
      @(negedge clock);
      chk("sentinel status", {29'd0, done, error, mem_we}, 32'd6);
      chk("sentinel rdata", rdata, 32'hFFFF_FFFF);
      @(negedge clock);
      chk("sentinel hold", {30'd0, busy, error}, 32'd1);
      run_txn("sentinel clears", 1'b0, 2'd1, 32'h0, 32'h0, 32'h3F41, 32'h3F40,
              32'd0, 32'h0000_3344, 4);
`else
      // Without the check a sentinel address is simply truncated to 0x3FFF
      run_txn("sentinel store", 1'b1, 2'd0, 32'h0, 32'h0, 32'h0, 32'hFFFF_FFFF,
              32'h0000_00E5, 32'd0, 2);
      run_txn("sentinel load", 1'b0, 2'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
              32'hFFFF_FFFF, 32'd0, 32'hE5E5_E5E5, 6);
`endif

      // Fill a 64-byte window, then random traffic inside it
      for (int i = 0; i < 16; i++) begin
         wd = $urandom();
         run_txn($sformatf("fill%0d", i), 1'b1, 2'd2, 32'h3F03 + 32'(4*i), 32'h3F02 + 32'(4*i),
                 32'h3F01 + 32'(4*i), 32'h3F00 + 32'(4*i), wd, 32'd0, 5);
      end
      for (int i = 0; i < 60; i++) begin
         wr = 1'($urandom_range(0, 1));
         sz = 2'($urandom_range(0, 3));
         for (int k = 0; k < 4; k++) begin
            r = $urandom();
            ra[k] = {r[31:ADDR_W], 14'h3F00 + 14'($urandom_range(0, 63))};
         end
         wd  = $urandom();
         exp = wr ? 32'd0 : model_load(sz, ra[3], ra[2], ra[1], ra[0]);
         run_txn($sformatf("rand%0d", i), wr, sz, ra[3], ra[2], ra[1], ra[0], wd, exp,
                 lanes_of(sz) + (wr ? 1 : 2));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/memory_access_sequencer.md
MEMORY_ACCESS_SEQUENCER -- requirements
Module: memory_access_sequencer

Interface
REQ-001 SHALL have parameter ADDR_W, default 14, width of mem_addr (covers 0x0000-0x3FFF, both stacks).
REQ-002 SHALL have port clock  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port start  input  1  request strobe; sampled only in IDLE.
REQ-005 SHALL have port write  input  1  1=store, 0=load; latched at accept.
REQ-006 SHALL have port size  input  2  0=byte (Byte0), 1=half (Byte1,Byte0), 2 or 3=word (Byte3..Byte0).
REQ-007 SHALL have ports Byte3, Byte2, Byte1, Byte0  input  32 each  per-lane byte addresses from the address handler.
REQ-008 SHALL have port wdata  input  32  store data; lane k = wdata[8k+7:8k].
REQ-009 SHALL have port mem_rdata  input  8  byte-wide synchronous RAM read data, valid one cycle after its address.
REQ-010 SHALL have port mem_addr  output  ADDR_W  RAM address = low ADDR_W bits of active lane address.
REQ-011 SHALL have port mem_wdata  output  8  RAM write byte.
REQ-012 SHALL have port mem_we  output  1  RAM write enable.
REQ-013 SHALL have port rdata  output  32  assembled load word; unused lanes zero.
REQ-014 SHALL have ports busy, done, error  output  1 each  status.

Function
REQ-015 SHALL implement states IDLE, ACCESS, DRAIN, DONE.
REQ-016 SHALL accept start only in IDLE, latching write, size, four addresses and wdata; start in any other state ignored.
REQ-017 SHALL, on accept, clear rdata and error and enter ACCESS next cycle.
REQ-018 SHALL in ACCESS present one lane per cycle in order Byte0, Byte1, Byte2, Byte3, limited to N lanes (N=1,2,4 per size), using a lane counter.
REQ-019 SHALL for stores drive mem_we=1 and mem_wdata = latched lane byte each ACCESS cycle; mem_we=0 in all other states.
REQ-020 SHALL for loads capture mem_rdata into rdata lane k one cycle after lane k's address; after last lane go to DRAIN for one capture cycle.
REQ-021 SHALL after last store lane go directly to DONE (store: DONE N+1 cycles after accept; load: N+2).
REQ-022 SHALL pulse done for exactly one cycle in DONE, then return to IDLE.
REQ-023 SHALL drive busy=1 in ACCESS, DRAIN, DONE; 0 in IDLE.
REQ-024 SHALL hold rdata and error stable from DONE until next accepted start.
REQ-025 SHALL hold mem_addr at 0 and mem_wdata at 0 in IDLE, DRAIN, DONE.
REQ-026 SHALL ignore upper address bits beyond ADDR_W (truncation, no wrap detection).

Reset
REQ-027 SHALL on reset low immediately enter IDLE; busy, done, error, mem_we = 0; mem_addr, mem_wdata, rdata = 0; lane counter = 0.
REQ-028 SHALL abandon any in-flight access on reset mid-operation; partial RAM writes already issued are not undone.
REQ-029 SHALL not accept start in the first edge while reset is low.

Configuration
REQ-030 SHALL with MAS_SENTINEL_CHECK_EN defined: if any used lane address equals 32'hFFFFFFFF at accept (empty-stack pop), skip ACCESS, enter DONE next cycle with error=1, rdata=32'hFFFFFFFF, no mem_we.
REQ-031 SHALL without MAS_SENTINEL_CHECK_EN: no check, error tied 0, sentinel addresses truncated and accessed normally.

Verification
REQ-032 Word store: size=2, Byte3..0=0x17FC..0x17FF, wdata=0xA1B2C3D4 -> mem_we cycles 1-4 at 0x17FF/D4, 0x17FE/C3, 0x17FD/B2, 0x17FC/A1; done at cycle 5.
REQ-033 Word load of REQ-032 addresses -> rdata=0xA1B2C3D4, done at cycle 6, busy 1 cycles 1-6.
REQ-034 Half load: size=1, Byte1=0x1001, Byte0=0x1002 holding 0x5A,0x3C -> rdata=0x00005A3C, done cycle 4; byte store size=0 -> single write, done cycle 2.
REQ-035 start held high during busy -> second request ignored; new request accepted only in cycle after done.
REQ-036 reset low during ACCESS lane 2 of word store -> outputs zero immediately, no further mem_we, lanes 2-3 unwritten.
REQ-037 With MAS_SENTINEL_CHECK_EN: load with all lanes 0xFFFFFFFF -> done cycle 1, error=1, rdata=0xFFFFFFFF, mem_we never 1; without macro error stays 0.
